// File: rtl/vga_timing_gen_pkg.sv
// Shared 1280x1024@60 raster constants and helpers for the timing generator,
// compositor and display modules.
package vga_timing_gen_pkg;

  localparam int unsigned H_ACTIVE = 1280;
  localparam int unsigned H_FP     = 48;
  localparam int unsigned H_SYNC   = 112;
  localparam int unsigned H_BP     = 248;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 1024;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 3;
  localparam int unsigned V_BP     = 38;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit H_POL = 1'b1;
  localparam bit V_POL = 1'b1;

  localparam int unsigned PIPE_DLY = 2;

  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
  } flags_t;

  // True when lo <= cnt < lo + len.
  function automatic logic in_window(input logic [10:0] cnt, input int unsigned lo,
                                     input int unsigned len);
    return (32'(cnt) >= lo) && (32'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_shift_delay.sv
// Enable-qualified register chain with synchronous clear; Depth of 0 degenerates to a wire.
module vga_timing_gen_shift_delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, reset_i, en_i};
    assign q_o = d_i;
  end else begin : g_chain
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        stage_q <= '{default: '0};
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source for the compositor plus the re-aligned, blanking-clean VGA output stage.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned HFp     = H_FP,
  parameter int unsigned HSync   = H_SYNC,
  parameter int unsigned HBp     = H_BP,
  parameter int unsigned VActive = V_ACTIVE,
  parameter int unsigned VFp     = V_FP,
  parameter int unsigned VSync   = V_SYNC,
  parameter int unsigned VBp     = V_BP,
  parameter bit          HPol    = H_POL,
  parameter bit          VPol    = V_POL,
  parameter int unsigned PipeDly = PIPE_DLY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        valid,
  output logic        vsync,
  output logic        frame_start,
  output logic [15:0] frame_count,
  input  logic [23:0] rgb_in,
  output logic [23:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync
);

  localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        started_q;
  logic        vis, hs_act, vs_act, at_origin;
  flags_t      flags_q, flags_dly;

  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (32'(hcnt_q) == HTotal - 1) begin
      hcnt_d = '0;
      vcnt_d = (32'(vcnt_q) == VTotal - 1) ? '0 : vcnt_q + 11'd1;
    end
    vis       = in_window(hcnt_q, 0, HActive) && in_window(vcnt_q, 0, VActive);
    hs_act    = in_window(hcnt_q, HActive + HFp, HSync);
    vs_act    = in_window(vcnt_q, VActive + VFp, VSync);
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
  end

  // Stage 1: counters and the compositor-facing outputs decoded from them.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      x           <= '0;
      y           <= '0;
      flags_q     <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
      started_q   <= 1'b0;
    end else if (pix_en) begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      x           <= vis ? hcnt_q : '0;
      y           <= vis ? vcnt_q[9:0] : '0;
      flags_q     <= '{valid: vis, hsync: hs_act, vsync: vs_act};
      // The first frame after reset is not announced; only later wraps to (0,0) are.
      frame_start <= started_q && at_origin;
      if (started_q && at_origin) begin
        frame_count <= frame_count + 16'd1;
      end
      started_q   <= 1'b1;
    end
  end

  assign valid = flags_q.valid;
  assign vsync = ~flags_q.vsync;

  // Flags wait out the compositor read latency so they line up with rgb_in.
  vga_timing_gen_shift_delay #(
    .Width($bits(flags_t)),
    .Depth(PipeDly)
  ) u_flag_delay (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (pix_en),
    .d_i    (flags_q),
    .q_o    (flags_dly)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb   <= '0;
      vga_hsync <= ~HPol;
      vga_vsync <= ~VPol;
    end else if (pix_en) begin
      vga_rgb   <= flags_dly.valid ? rgb_in : '0;
      vga_hsync <= flags_dly.hsync ^ ~HPol;
      vga_vsync <= flags_dly.vsync ^ ~VPol;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size timing instance plus a shrunken-raster instance for frame-level checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        vsync;
    logic        fs;
    logic [15:0] fc;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic clk = 1'b0;
  logic reset, pix_en;
  always #5 clk = ~clk;

  // Full-size instance
  logic [10:0] m_x;
  logic [9:0]  m_y;
  logic        m_valid, m_vsync, m_fs, m_vga_hs, m_vga_vs;
  logic [15:0] m_fc;
  logic [23:0] m_rgb_in, m_vga_rgb;
  logic [23:0] m_pipe0 = '0, m_pipe1 = '0;

  vga_timing_gen u_main (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .x          (m_x),
    .y          (m_y),
    .valid      (m_valid),
    .vsync      (m_vsync),
    .frame_start(m_fs),
    .frame_count(m_fc),
    .rgb_in     (m_rgb_in),
    .vga_rgb    (m_vga_rgb),
    .vga_hsync  (m_vga_hs),
    .vga_vsync  (m_vga_vs)
  );

  // Small raster: 16 x 11 = 176 pixel clocks per frame
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic        s_valid, s_vsync, s_fs, s_vga_hs, s_vga_vs;
  logic [15:0] s_fc;
  logic [23:0] s_rgb_in, s_vga_rgb;
  logic [23:0] s_pipe0 = '0, s_pipe1 = '0;

  vga_timing_gen #(
    .HActive(8), .HFp(2), .HSync(3), .HBp(3),
    .VActive(6), .VFp(1), .VSync(2), .VBp(2)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .x          (s_x),
    .y          (s_y),
    .valid      (s_valid),
    .vsync      (s_vsync),
    .frame_start(s_fs),
    .frame_count(s_fc),
    .rgb_in     (s_rgb_in),
    .vga_rgb    (s_vga_rgb),
    .vga_hsync  (s_vga_hs),
    .vga_vsync  (s_vga_vs)
  );

  // Compositor models: two-cycle pixel-rate delay of {x, y, A5}; not cleared by reset.
  always @(posedge clk) begin
    if (pix_en) begin
      m_pipe0 <= {m_x[7:0], m_y[7:0], 8'hA5};
      m_pipe1 <= m_pipe0;
      s_pipe0 <= {s_x[7:0], s_y[7:0], 8'hA5};
      s_pipe1 <= s_pipe0;
    end
  end
  assign m_rgb_in = m_pipe1;
  assign s_rgb_in = s_pipe1;

  int   checks = 0, errors = 0;
  int   clk_cnt = 0;
  logic en_e = 1'b0, rs_e = 1'b0, seen = 1'b0;
  exp_t q_main[$], q_small[$];
  int   hs_rises[$], rgb_rises[$], fs_at[$];
  int   j = 0;

  always @(posedge clk) begin
    clk_cnt <= clk_cnt + 1;
    en_e    <= pix_en;
    rs_e    <= reset;
    seen    <= 1'b1;
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cmp(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @clk %0d: got %h want %h", name, clk_cnt, got, want);
    end
  endtask

  // Expected outputs after the j-th enabled edge since reset (j = 0: reset state).
  function automatic exp_t model(input int jj, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp);
    int ht, vt, ft, p, h, v;
    exp_t e;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    ft = ht * vt;
    e = '{x: '0, y: '0, valid: 1'b0, vsync: 1'b1, fs: 1'b0, fc: '0, rgb: '0, hs: 1'b0, vs: 1'b0};
    if (jj >= 1) begin
      p = jj - 1;
      h = p % ht;
      v = (p / ht) % vt;
      e.valid = (h < ha) && (v < va);
      if (e.valid) begin
        e.x = 11'(h);
        e.y = 10'(v);
      end
      e.vsync = !((v >= va + vfp) && (v < va + vfp + vsw));
      e.fs    = (p > 0) && (p % ft == 0);
      e.fc    = 16'(p / ft);
    end
    if (jj >= 4) begin
      p = jj - 4;
      h = p % ht;
      v = (p / ht) % vt;
      if ((h < ha) && (v < va)) e.rgb = {8'(h), 8'(v), 8'hA5};
      e.hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
      e.vs = (v >= va + vfp) && (v < va + vfp + vsw);
    end
    return e;
  endfunction

  task automatic push_exp();
    q_main.push_back(model(j, 1280, 48, 112, 248, 1024, 1, 3, 38));
    q_small.push_back(model(j, 8, 2, 3, 3, 6, 1, 2, 2));
  endtask

  task automatic drive(input logic r, input logic e);
    @(negedge clk);
    reset  = r;
    pix_en = e;
    if (r) j = 0;
    else if (e) j++;
    if (r || e) push_exp();
  endtask

  // Monitor: pops one expectation per reset/enabled edge; hold edges must not change anything.
  exp_t am, as_, prev_m, prev_s, e_m, e_s;
  int   vrun = 0, hrun = 0, en_cnt = 0;
  always @(negedge clk) begin
    am  = '{x: m_x, y: m_y, valid: m_valid, vsync: m_vsync, fs: m_fs, fc: m_fc,
            rgb: m_vga_rgb, hs: m_vga_hs, vs: m_vga_vs};
    as_ = '{x: s_x, y: s_y, valid: s_valid, vsync: s_vsync, fs: s_fs, fc: s_fc,
            rgb: s_vga_rgb, hs: s_vga_hs, vs: s_vga_vs};
    if (seen) begin
      if (rs_e || en_e) begin
        if (q_main.size() == 0 || q_small.size() == 0) begin
          check("scoreboard_underflow", 0, 1);
        end else begin
          e_m = q_main.pop_front();
          e_s = q_small.pop_front();
          cmp("main", am, e_m);
          cmp("small", as_, e_s);
        end
      end else begin
        cmp("main_hold", am, prev_m);
        cmp("small_hold", as_, prev_s);
      end
      if (rs_e) begin
        vrun = 0;
        hrun = 0;
        en_cnt = 0;
        fs_at.delete();
      end else if (en_e) begin
        en_cnt++;
        if (m_valid) vrun++;
        else if (prev_m.valid) begin
          check("valid_run", vrun, 1280);
          vrun = 0;
        end
        if (m_vga_hs) hrun++;
        else if (prev_m.hs) begin
          check("hsync_run", hrun, 112);
          hrun = 0;
        end
        if (s_fs) fs_at.push_back(en_cnt);
      end
      if (m_vga_hs && !prev_m.hs) hs_rises.push_back(clk_cnt);
      if ((m_vga_rgb != 0) && (prev_m.rgb == 0)) rgb_rises.push_back(clk_cnt);
    end
    prev_m = am;
    prev_s = as_;
  end

  task automatic check_hs_period(input int period);
    if (hs_rises.size() < 2) check("hs_rise_count", hs_rises.size(), 2);
    else for (int i = 1; i < hs_rises.size(); i++) begin
      check("hs_period", hs_rises[i] - hs_rises[i-1], period);
    end
  endtask

  task automatic check_hs_offset();
    if (hs_rises.size() == 0 || rgb_rises.size() == 0) check("hs_rgb_rises", 0, 1);
    else check("hs_after_rgb", hs_rises[0] - rgb_rises[0], 1328);
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b1;
    push_exp();
    repeat (4) drive(1'b1, 1'b1);

    // Three full lines at full pixel rate
    repeat (3 * 1688 + 10) drive(1'b0, 1'b1);
    check_hs_period(1688);
    check_hs_offset();

    // Half-rate enable: every period doubles in clocks
    hs_rises.delete();
    rgb_rises.delete();
    for (int k = 0; k < 7000; k++) drive(1'b0, (k % 2) == 0);
    check_hs_period(3376);

    // Mid-line reset, then restart from (0,0)
    while ((j % 1688) != 700) drive(1'b0, 1'b1);
    hs_rises.delete();
    rgb_rises.delete();
    drive(1'b1, 1'b1);
    repeat (2000) drive(1'b0, 1'b1);
    check_hs_offset();

    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check("q_main_left", q_main.size(), 0);
    check("q_small_left", q_small.size(), 0);
    if (fs_at.size() < 2) check("fs_count", fs_at.size(), 2);
    else for (int i = 1; i < fs_at.size(); i++) check("fs_period", fs_at[i] - fs_at[i-1], 176);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
